dir_input_ctrl: RTL and testbench

//  Turns four raw direction buttons into the per-step direction request (o_Push) for head-position logic.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 39 +++
 rtl/dir_input_ctrl.sv | 109 ++++++++++
 tb/tb_dir_input_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Direction codes and helpers shared by the button front end and the head-update logic.
package snake_pkg;

   localparam int unsigned NUM_DIRS = 4;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      RIGHT = 2'd2,
      LEFT  = 2'd3
   } dir_t;

   function automatic dir_t dir_reverse(input dir_t d);
      dir_t r;
      case (d)
         UP:      r = DOWN;
         DOWN:    r = UP;
         RIGHT:   r = LEFT;
         default: r = RIGHT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stability counter that owns the debounced level.
module btn_debounce #(
   parameter int DEB_CYCLES = 250000,
   parameter int DEB_W      = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [DEB_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // Any sample agreeing with the current level restarts the stability count.
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == DEB_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dir_input_ctrl.sv
// Button front end: debounce, press priority, optional direction filter and a small turn queue.
// Optional filter enabled by defining DIR_QUEUE_FILTER_EN; reset release is expected synchronous to i_Clk.
module dir_input_ctrl
   import snake_pkg::*;
#(
   parameter int DEB_CYCLES = 250000,
   parameter int DEB_W      = 18,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic [NUM_DIRS-1:0] i_Btn,
   input  logic                i_Tick,
   input  logic [1:0]          i_Way,
   output logic [1:0]          o_Push,
   output logic                o_Valid,
   output logic [NUM_DIRS-1:0] o_Btn_Db,
   output logic                o_Drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   logic [NUM_DIRS-1:0] db_prev;
   logic [NUM_DIRS-1:0] rise;
   logic                press_vld;
   dir_t                press_dir;
   logic                accept;
   logic                full;
   logic                pop;
   logic                push;
   logic                drop_evt;

   dir_t                mem [FIFO_DEPTH];
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic [AW:0]         count;

   for (genvar g = 0; g < NUM_DIRS; g++) begin : g_deb
      btn_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .DEB_W      (DEB_W)
      ) u_deb (
         .clk   (i_Clk),
         .rst_n (i_Rst),
         .raw   (i_Btn[g]),
         .level (o_Btn_Db[g])
      );
   end

   assign rise = o_Btn_Db & ~db_prev;

   // Lowest index wins when several buttons rise together; the rest vanish silently.
   always_comb begin
      press_vld = 1'b0;
      press_dir = UP;
      for (int i = NUM_DIRS - 1; i >= 0; i--) begin
         if (rise[i]) begin
            press_vld = 1'b1;
            press_dir = dir_t'(2'(i));
         end
      end
   end

`ifdef DIR_QUEUE_FILTER_EN
   logic [AW-1:0] last_ptr;
   dir_t          ref_dir;

   assign last_ptr = wr_ptr - AW'(1);
   assign ref_dir  = (count != '0) ? mem[last_ptr] : dir_t'(i_Way);
   assign accept   = press_vld && (press_dir != ref_dir) && (press_dir != dir_reverse(ref_dir));
`else
   assign accept   = press_vld;
`endif

   assign full     = (count == FULL_CNT);
   assign pop      = i_Tick && (count != '0);
   assign push     = accept && (!full || pop);
   assign drop_evt = accept && full && !pop;

   assign o_Valid  = (count != '0);
   assign o_Push   = o_Valid ? mem[rd_ptr] : i_Way;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         db_prev <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         o_Drop  <= 1'b0;
      end else begin
         db_prev <= o_Btn_Db;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop_evt) o_Drop <= 1'b1;
      end
   end

   // Queue storage carries data only; validity is tracked by the pointers and count.
   always_ff @(posedge i_Clk) begin
      if (push) mem[wr_ptr] <= press_dir;
   end

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Scoreboard bench for dir_input_ctrl with short debounce and a two-entry queue.
module tb_dir_input_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] btn = 4'b0000;
   logic       tick = 1'b0;
   logic [1:0] way = 2'd2;
   logic [1:0] o_Push;
   logic       o_Valid;
   logic [3:0] o_Btn_Db;
   logic       o_Drop;

   int checks = 0;
   int failures = 0;
   logic [1:0] exp_q [$];
   logic [1:0] exp_d;

   dir_input_ctrl #(
      .DEB_CYCLES (4),
      .DEB_W      (3),
      .FIFO_DEPTH (2)
   ) dut (
      .i_Clk    (clk),
      .i_Rst    (rst_n),
      .i_Btn    (btn),
      .i_Tick   (tick),
      .i_Way    (way),
      .o_Push   (o_Push),
      .o_Valid  (o_Valid),
      .o_Btn_Db (o_Btn_Db),
      .o_Drop   (o_Drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   // Hold mask long enough to debounce; optionally tick in the cycle the press reaches the queue.
   task automatic press(input logic [3:0] mask, input bit with_tick, input bit accepted,
                        input logic [1:0] dir);
      btn = mask;
      repeat (6) step();
      tick = with_tick;
      if (accepted) exp_q.push_back(dir);
      step();
      tick = 1'b0;
      step();
      btn = 4'b0000;
      repeat (8) step();
   endtask

   // Monitor: every tick that consumes a queued entry must present the next expected direction.
   always @(negedge clk) begin
      if (rst_n && tick && o_Valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%0h required=none", o_Push);
         end else begin
            exp_d = exp_q.pop_front();
            check("pop_dir", {6'd0, o_Push}, {6'd0, exp_d});
         end
      end
   end

   initial begin
      // 1. Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", {7'd0, o_Valid}, 8'd0);
      check("rst_push", {6'd0, o_Push}, 8'd2);
      check("rst_db", {4'd0, o_Btn_Db}, 8'd0);
      check("rst_drop", {7'd0, o_Drop}, 8'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // 2. Glitch shorter than debounce, then a real press
      btn = 4'b0001;
      repeat (3) step();
      btn = 4'b0000;
      repeat (8) step();
      check("glitch_db", {4'd0, o_Btn_Db}, 8'd0);
      check("glitch_valid", {7'd0, o_Valid}, 8'd0);
      btn = 4'b0001;
      repeat (5) step();
      check("deb_c5", {4'd0, o_Btn_Db}, 8'd0);
      step();
      check("deb_c6", {4'd0, o_Btn_Db}, 8'd1);
      check("deb_c6_valid", {7'd0, o_Valid}, 8'd0);
      exp_q.push_back(2'd0);
      step();
      check("press_valid", {7'd0, o_Valid}, 8'd1);
      check("press_push", {6'd0, o_Push}, 8'd0);
      btn = 4'b0000;
      repeat (8) step();
      do_tick();
      check("drain2_valid", {7'd0, o_Valid}, 8'd0);

      // 3. Two quick turns buffered
      way = 2'd2;
      press(4'b0001, 1'b0, 1'b1, 2'd0);
      press(4'b1000, 1'b0, 1'b1, 2'd3);
      check("q3_head", {6'd0, o_Push}, 8'd0);
      do_tick();
      check("q3_second", {6'd0, o_Push}, 8'd3);
      do_tick();
      check("q3_empty_valid", {7'd0, o_Valid}, 8'd0);
      check("q3_empty_push", {6'd0, o_Push}, 8'd2);

      // 1b. Reset mid-queue empties it at once
      press(4'b0001, 1'b0, 1'b1, 2'd0);
      check("midq_valid", {7'd0, o_Valid}, 8'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {7'd0, o_Valid}, 8'd0);
      check("midrst_push", {6'd0, o_Push}, 8'd2);
      exp_q.delete();
      step();
      rst_n = 1'b1;
      step();

      // 4. Same direction and reversal
      way = 2'd0;
`ifdef DIR_QUEUE_FILTER_EN
      press(4'b0010, 1'b0, 1'b0, 2'd1);
      press(4'b0001, 1'b0, 1'b0, 2'd0);
      check("filt_valid", {7'd0, o_Valid}, 8'd0);
      check("filt_push", {6'd0, o_Push}, 8'd0);
`else
      press(4'b0010, 1'b0, 1'b1, 2'd1);
      press(4'b0001, 1'b0, 1'b1, 2'd0);
      check("nofilt_valid", {7'd0, o_Valid}, 8'd1);
      check("nofilt_push", {6'd0, o_Push}, 8'd1);
      do_tick();
      do_tick();
      check("nofilt_drain", {7'd0, o_Valid}, 8'd0);
`endif

      // 5. Full queue: drop without tick, accept with simultaneous pop
      way = 2'd1;
      press(4'b0100, 1'b0, 1'b1, 2'd2);
      press(4'b0001, 1'b0, 1'b1, 2'd0);
      check("full_nodrop", {7'd0, o_Drop}, 8'd0);
      press(4'b1000, 1'b0, 1'b0, 2'd3);
      check("full_drop", {7'd0, o_Drop}, 8'd1);
      press(4'b1000, 1'b1, 1'b1, 2'd3);
      check("pushpop_head", {6'd0, o_Push}, 8'd0);
      check("pushpop_valid", {7'd0, o_Valid}, 8'd1);
      do_tick();
      check("pushpop_second", {6'd0, o_Push}, 8'd3);
      do_tick();
      check("pushpop_empty", {7'd0, o_Valid}, 8'd0);
      check("drop_sticky", {7'd0, o_Drop}, 8'd1);
      rst_n = 1'b0;
      #1;
      check("drop_rst", {7'd0, o_Drop}, 8'd0);
      step();
      rst_n = 1'b1;
      step();

      // 6. Simultaneous rises: lowest index only
      way = 2'd0;
      press(4'b1100, 1'b0, 1'b1, 2'd2);
      check("multi_push", {6'd0, o_Push}, 8'd2);
      check("multi_valid", {7'd0, o_Valid}, 8'd1);
      check("multi_drop", {7'd0, o_Drop}, 8'd0);
      do_tick();
      check("multi_single", {7'd0, o_Valid}, 8'd0);

      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
